// File: rtl/tc_sram_arb.sv
// Round-robin arbiter that shares one single-port SRAM among NumReq requesters.
// Read responses are routed back through a Latency-deep tag pipeline.
module tc_sram_arb #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*BeWidth-1:0]     req_be_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [AddrWidth-1:0]          sram_addr_o,
  output logic [DataWidth-1:0]          sram_wdata_o,
  output logic [BeWidth-1:0]            sram_be_o,
  input  logic [DataWidth-1:0]          sram_rdata_i
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] gnt_idx;
  logic                gnt_vld;
  int unsigned         arb_dist, arb_best;

  logic [Latency-1:0]               pipe_vld_q, pipe_vld_d;
  logic [Latency-1:0][IdxWidth-1:0] pipe_idx_q, pipe_idx_d;
  logic                             rd_push;

  // Winner is the valid requester with the smallest rotated distance from ptr_q.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    arb_best = NumReq;
    arb_dist = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      arb_dist = (i + NumReq - 32'(ptr_q)) % NumReq;
      if (req_valid_i[i] && (arb_dist < arb_best)) begin
        arb_best = arb_dist;
        gnt_idx  = IdxWidth'(i);
        gnt_vld  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = gnt_vld && (gnt_idx == IdxWidth'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + IdxWidth'(1);
    end
  end

  assign sram_req_o = |(req_valid_i & req_ready_o);

  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_ready_o[i]) begin
        sram_we_o    = req_we_i[i];
        sram_addr_o  = req_addr_i[i*AddrWidth +: AddrWidth];
        sram_wdata_o = req_wdata_i[i*DataWidth +: DataWidth];
        sram_be_o    = req_be_i[i*BeWidth +: BeWidth];
      end
    end
  end

  // Writes produce no response, so only granted reads enter the tag pipeline as valid.
  assign rd_push = sram_req_o & ~sram_we_o;

  always_comb begin
    pipe_vld_d    = '0;
    pipe_idx_d    = '0;
    pipe_vld_d[0] = rd_push;
    pipe_idx_d[0] = gnt_idx;
    for (int unsigned s = 1; s < Latency; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (pipe_vld_q[Latency-1]) begin
      rsp_rdata_o = sram_rdata_i;
      for (int unsigned i = 0; i < NumReq; i++) begin
        rsp_valid_o[i] = (pipe_idx_q[Latency-1] == IdxWidth'(i));
      end
    end
  end

  ready_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  ready_needs_valid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_ready_o & ~req_valid_i) == '0);
  rsp_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));

endmodule

// File: doc/tc_sram_arb.md
TC_SRAM_ARB -- requirements
Module: tc_sram_arb

Interface
REQ-001 SHALL have parameter NumReq, default 2: number of requesters, at least 1.
REQ-002 SHALL have parameter NumWords, default 1024: SRAM depth.
REQ-003 SHALL have parameter DataWidth, default 32: data width in bits.
REQ-004 SHALL have parameter ByteWidth, default 8: width of one byte-enable lane.
REQ-005 SHALL have parameter Latency, default 1: SRAM read latency in cycles, at least 1.
REQ-006 SHALL have derived parameters AddrWidth = max(1, clog2(NumWords)), BeWidth = ceil(DataWidth/ByteWidth) and IdxWidth = max(1, clog2(NumReq)).
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port req_valid_i, input, NumReq bits: per-requester request valid.
REQ-010 SHALL have port req_ready_o, output, NumReq bits: per-requester grant; a handshake occurs when valid and ready are both high.
REQ-011 SHALL have port req_we_i, input, NumReq bits: write enable per requester.
REQ-012 SHALL have port req_addr_i, input, NumReq x AddrWidth bits.
REQ-013 SHALL have port req_wdata_i, input, NumReq x DataWidth bits.
REQ-014 SHALL have port req_be_i, input, NumReq x BeWidth bits.
REQ-015 SHALL have port rsp_valid_o, output, NumReq bits: read data valid, one-hot or zero.
REQ-016 SHALL have port rsp_rdata_o, output, DataWidth bits: read data, shared by all requesters.
REQ-017 SHALL have ports sram_req_o (1), sram_we_o (1), sram_addr_o (AddrWidth), sram_wdata_o (DataWidth) and sram_be_o (BeWidth), all outputs, driving a single-port tc_sram.
REQ-018 SHALL have port sram_rdata_i, input, DataWidth bits: SRAM read data, valid Latency cycles after the request.

Function
REQ-019 SHALL grant at most one requester per cycle: req_ready_o is one-hot or zero, and req_ready_o[i] is high only if req_valid_i[i] is high.
REQ-020 SHALL arbitrate round-robin using a priority pointer ptr_q (IdxWidth bits), granting the first valid requester at index ptr_q, ptr_q+1, ... modulo NumReq.
REQ-021 SHALL, after a handshake by requester g, set ptr_q to g+1, wrapping to 0 when g = NumReq-1; with no handshake, ptr_q SHALL hold.
REQ-022 SHALL generate the grant combinationally from req_valid_i, so a requester never waits more than NumReq-1 cycles while its valid is held.
REQ-023 SHALL drive sram_req_o = OR of the handshakes, and SHALL forward we, addr, wdata and be of the granted requester combinationally to the sram_* outputs (0 when not granted).
REQ-024 SHALL track every granted read in a Latency-deep shift pipeline whose stages each hold a valid bit and IdxWidth index bits; writes enter as invalid.
REQ-025 SHALL, when the pipeline output stage is valid with index k, drive rsp_valid_o[k] = 1 and rsp_rdata_o = sram_rdata_i in the same cycle, exactly Latency cycles after the handshake.
REQ-026 SHALL drive rsp_rdata_o = 0 when no response is valid.
REQ-027 SHALL not support response backpressure: requesters accept rsp_valid_o unconditionally.
REQ-028 SHALL sustain one request per cycle with reads and writes mixed back to back and no bubbles.
REQ-029 SHALL, for NumReq = 1, reduce to pass-through: req_ready_o = req_valid_i and ptr_q constant 0.
REQ-030 SHALL never alter read-to-response ordering: responses appear in grant order.
REQ-031 SHALL not check address range; out-of-range addresses are forwarded unchanged.

Reset
REQ-032 SHALL, while rst_ni is low, force ptr_q = 0, clear every pipeline valid bit, and drive rsp_valid_o = 0; req_ready_o and sram_* SHALL follow REQ-019 to REQ-023 combinationally.
REQ-033 SHALL drop any reads in flight when reset is asserted mid-operation: no rsp_valid_o after deassertion for requests granted before reset.
REQ-034 SHALL start the first arbitration after reset deassertion with requester 0 at top priority.

Verification
REQ-035 Scenario, single read: NumReq=2, Latency=1; requester 0 reads address 0x5 after a prior write of 0xDEADBEEF -> req_ready_o=01 in the request cycle; one cycle later rsp_valid_o=01 and rsp_rdata_o=0xDEADBEEF.
REQ-036 Scenario, fairness: NumReq=3; all valids held high for 6 cycles -> grants 0,1,2,0,1,2 and ptr_q wraps from 2 to 0.
REQ-037 Scenario, latency routing: Latency=3; reads granted to requesters 1, 0, 1 in consecutive cycles -> rsp_valid_o=10, 01, 10 on cycles +3, +4, +5 with matching data.
REQ-038 Scenario, byte enables: write 0x11223344 with be=0b0101 over 0x00000000, then read -> 0x00220044.
REQ-039 Scenario, reset mid-flight: Latency=2, read granted, rst_ni pulsed low the next cycle -> no rsp_valid_o ever asserts for that read, and ptr_q=0 afterward.
REQ-040 Scenario, idle: no valids for 10 cycles -> sram_req_o=0, req_ready_o=0, rsp_valid_o=0, ptr_q unchanged.
